mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Arbiter/sequencer sharing one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. Grants one access at a time, drives the memory port, returns read data to the winner, and produces stall signals so fetch and memory stages hold while their access is pending. Sits between the pipeline stages and the unified memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid; legal range 1..15
STARVE_MAX, 4, max consecutive DM grants while if_req pending before IF is forced; range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_req  in  1  fetch read request; held until if_valid
if_addr  in  ADDR_W  fetch address; stable while if_req
if_rdata  out  DATA_W  instruction data; valid with if_valid
if_valid  out  1  one-cycle completion pulse to fetch
dm_req  in  1  data access request; held until dm_valid
dm_we  in  1  1=store, 0=load; stable while dm_req
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data; valid with dm_valid
dm_valid  out  1  one-cycle completion pulse to memory stage
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en cycle
stall_f  out  1  if_req & ~if_valid
stall_m  out  1  dm_req & ~dm_valid
busy  out  1  state != IDLE

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; mem_en, mem_we, if_valid, dm_valid=0; mem_addr, mem_wdata, if_rdata, dm_rdata=0; wait counter and starvation counter=0. In-flight memory response discarded; no valid pulse follows reset.
- FSM: IDLE -> WAIT -> DONE -> IDLE.
- IDLE: if any req, grant per arbitration; register mem_en=1, mem_we=(DM grant ? dm_we : 0), mem_addr/mem_wdata from winner (IF: wdata=0), owner flag, cnt=MEM_LAT; go WAIT. No req: stay IDLE.
- WAIT: mem_en=1 only in first WAIT cycle, then 0. cnt decrements each cycle; at cnt==0 sample mem_rdata into owner's rdata register (stores: rdata cleared to 0); go DONE.
- DONE: pulse owner's valid one cycle; requests ignored this cycle; go IDLE.
- Latency req-seen-in-IDLE to valid = MEM_LAT+2 cycles; throughput one access per MEM_LAT+3 cycles. Stores take same latency as loads.
- Arbitration: DM wins over IF, except when starve_cnt==STARVE_MAX and if_req=1, then IF wins. starve_cnt increments (saturating at STARVE_MAX) on DM grant while if_req=1; cleared on IF grant or when if_req=0 in IDLE.
- Requester deasserting req mid-access: access completes, valid still pulses; ignored by requester.
- stall_f/stall_m combinational from inputs and registered valid; no other combinational path input->output.
- Unused rdata registers hold last value.

Optional Feature:
ARB_PERF_EN: adds outputs perf_if_stall[31:0], perf_dm_stall[31:0]; saturating counters of cycles with stall_f / stall_m high, cleared by rst. Without macro: ports and logic absent; arbitration unchanged.

Decomposition:
- Package arb_pkg: state typedef (IDLE=2'b00, WAIT=2'b01, DONE=2'b10), owner constants OWN_IF=1'b0, OWN_DM=1'b1, counter widths.
- Sub-module sat_counter (32-bit saturating, sync clear, enable), instantiated twice under ARB_PERF_EN.

Test Plan:
- rst=1 two cycles with if_req=1, dm_req=1 -> mem_en=0, valids=0, busy=0; after rst drops, mem_en high exactly one cycle later.
- MEM_LAT=2, if_req at cycle 0, if_addr=0x00000010, memory returns 0x00500093 -> mem_en cycle 1, mem_addr=0x10, if_valid cycle 4 with if_rdata=0x00500093; stall_f high cycles 0-3, low cycle 4.
- Both req at cycle 0 -> DM granted (mem_addr=dm_addr), dm_valid cycle 4; IF granted cycle 5, if_valid cycle 9.
- STARVE_MAX=2, if_req held, dm_req reasserted every cycle after dm_valid -> grant order DM, DM, IF, DM; starve_cnt back to 0 after IF grant.
- Store dm_we=1, addr 0x100, wdata 0xDEADBEEF -> mem_en=mem_we=1 cycle 1, dm_valid cycle 4; subsequent load 0x100 returns dm_rdata=0xDEADBEEF.
- rst asserted in WAIT (cycle 2) -> no valid pulse, state IDLE; with ARB_PERF_EN, perf counters read 0 after reset and perf_if_stall=4 after a single uncontended IF access.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the fetch/memory-stage port arbiter.
// Optional perf counters are enabled with ARB_PERF_EN.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int CNT_W    = 4;
  localparam int STARVE_W = 4;
  localparam int PERF_W   = 32;

endpackage

// File: rtl/sat_counter.sv
// 32-bit saturating event counter with synchronous clear.
// Used for the stall counters when ARB_PERF_EN is defined.
module sat_counter
  import arb_pkg::*;
(
  input  logic              clk,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q;
  logic [PERF_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {PERF_W{1'b1}}))
      cnt_d = cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and memory stages.
// Define ARB_PERF_EN to add saturating stall-cycle counters.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_f,
  output logic              stall_m,
  output logic              busy
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_dm_stall
`endif
);

  localparam logic [CNT_W-1:0]    LAT  = CNT_W'(MEM_LAT);
  localparam logic [STARVE_W-1:0] SMAX = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                own_q, own_d;
  logic                st_q, st_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                dm_valid_q, dm_valid_d;
  logic                pick_if;

  // IF only beats a pending DM once DM has won STARVE_MAX times in a row
  assign pick_if = if_req & (~dm_req | (starve_q == SMAX));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    own_d       = own_q;
    st_d        = st_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (if_req || dm_req) begin
          state_d  = WAIT;
          cnt_d    = LAT;
          mem_en_d = 1'b1;
          if (pick_if) begin
            own_d       = OWN_IF;
            st_d        = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            starve_d    = '0;
          end else begin
            own_d       = OWN_DM;
            st_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (if_req && starve_q != SMAX)
              starve_d = starve_q + STARVE_W'(1);
          end
        end
      end
      WAIT: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (own_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            dm_rdata_d = st_q ? '0 : mem_rdata;
            dm_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      own_q       <= OWN_IF;
      st_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      own_q       <= own_d;
      st_q        <= st_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign stall_f   = if_req & ~if_valid_q;
  assign stall_m   = dm_req & ~dm_valid_q;
  assign busy      = (state_q != IDLE);

`ifdef ARB_PERF_EN
  sat_counter u_perf_if (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (stall_f),
    .cnt_o (perf_if_stall)
  );

  sat_counter u_perf_dm (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (stall_m),
    .cnt_o (perf_dm_stall)
  );
`endif

endmodule
